alu_seq: RTL

- Next-generation execute unit for the RISC-V core.
- Covers the RV32I integer ops with parametrised datapath width and a registered, handshaked result.
- Adds an optional iterative M-extension unit (MUL*/DIV*/REM*), which takes multiple cycles.
- Sits between decode/operand fetch (upstream valid/ready) and writeback (downstream valid/ready). A flush input lets the pipeline cancel in-flight ops.

---
 rtl/alu_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: RV32I execute unit with optional iterative M-extension.
// Registered, valid/ready handshaked result; flush cancels in-flight ops.
module alu_seq #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [2:0]      func,
  input  logic            alt,
  input  logic            muldiv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic            take;
  logic            m_op;
  logic            bad_op;
  logic            iter_last;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] m_res;
  logic [SHAMT_W-1:0] shamt;
  logic            slt;
  logic            sltu;

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign take      = accept && !flush;
  assign m_op      = muldiv && ENABLE_M;
  assign bad_op    = muldiv && !ENABLE_M;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign illegal   = ill_q;

  assign shamt = rhs[SHAMT_W-1:0];
  assign slt   = $signed(lhs) < $signed(rhs);
  assign sltu  = lhs < rhs;

  // Single-cycle RV32I operations on the live input operands
  always_comb begin
    base_res = '0;
    case (func)
      3'b000: base_res = alt ? lhs - rhs : lhs + rhs;
      3'b001: base_res = lhs << shamt;
      3'b010: base_res = {{(XLEN-1){1'b0}}, slt};
      3'b011: base_res = {{(XLEN-1){1'b0}}, sltu};
      3'b100: base_res = lhs ^ rhs;
      3'b101: base_res = alt ? XLEN'($signed(lhs) >>> shamt)
                             : lhs >> shamt;
      3'b110: base_res = lhs | rhs;
      3'b111: base_res = lhs & rhs;
      default: base_res = '0;
    endcase
  end

  // Next state and result register update; flush wins over everything
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_d = m_op ? S_BUSY : S_DONE;
            ill_d   = bad_op;
            if (!m_op) res_d = bad_op ? '0 : base_res;
          end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          if (iter_last) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          state_d = S_DONE;
          res_d   = m_res;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  if (ENABLE_M) begin : g_m
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q, mc_q;
    logic [2:0]        fn_q;
    logic              neg_q;
    logic              sa, sb, rz;
    logic [XLEN-1:0]   amag, bmag;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     rt;
    logic [XLEN-1:0]   rtry;
    logic              rge;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   dv, dv_f;

    // Operand signedness and magnitudes, taken at accept
    always_comb begin
      rz = (rhs == '0);
      if (func[2]) begin
        sa = lhs[XLEN-1] && !func[0];
        sb = rhs[XLEN-1] && !func[0];
      end else begin
        sa = lhs[XLEN-1] && (func[1:0] != 2'b11);
        sb = rhs[XLEN-1] && !func[1];
      end
      amag = sa ? -lhs : lhs;
      bmag = sb ? -rhs : rhs;
    end

    // One shift-add or restoring-divide step
    always_comb begin
      msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
      rt   = {hi_q, lo_q[XLEN-1]};
      rtry = rt[XLEN-1:0] - mc_q;
      rge  = rt >= {1'b0, mc_q};
    end

    // Sign correction and half/quotient/remainder selection
    always_comb begin
      prod   = {hi_q, lo_q};
      prod_f = neg_q ? -prod : prod;
      dv     = fn_q[1] ? hi_q : lo_q;
      dv_f   = neg_q ? -dv : dv;
      if (fn_q[2])
        m_res = dv_f;
      else if (fn_q[1:0] == 2'b00)
        m_res = prod_f[XLEN-1:0];
      else
        m_res = prod_f[2*XLEN-1:XLEN];
    end

    assign iter_last = (state_q == S_BUSY) &&
                       (cnt_q == CW'(XLEN-1));

    // Iteration registers: load on accept, step once per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        hi_q  <= '0;
        lo_q  <= '0;
        mc_q  <= '0;
        fn_q  <= '0;
        neg_q <= 1'b0;
      end else if (take && m_op) begin
        cnt_q <= '0;
        hi_q  <= '0;
        lo_q  <= func[2] ? amag : bmag;
        mc_q  <= func[2] ? bmag : amag;
        fn_q  <= func;
        if (!func[2])
          neg_q <= sa ^ sb;
        else if (func[1])
          neg_q <= sa;
        else
          neg_q <= (sa ^ sb) && !rz;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        if (fn_q[2]) begin
          hi_q <= rge ? rtry : rt[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], rge};
        end else begin
          hi_q <= msum[XLEN:1];
          lo_q <= {msum[0], lo_q[XLEN-1:1]};
        end
      end
    end
  end else begin : g_nom
    assign iter_last = 1'b0;
    assign m_res     = '0;
  end

endmodule
